// File: rtl/updown_gray_counter_system.sv
// updown_gray_counter_system
//   Two debounced push-buttons drive an N-bit up/down counter with optional
//   hold-to-repeat, a wrap-or-saturate boundary policy and a Gray/binary LED
//   display selectable at run time.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        synchronous, active-high reset
//   btn_up     raw asynchronous up button, active high
//   btn_dn     raw asynchronous down button, active high
//   mode_gray  1: leds show Gray code of count, 0: leds show binary count
//   wrap_en    1: wrap at the boundaries, 0: saturate
//   leds       display value (combinational from count_bin)
//   count_bin  registered binary count
//   step_evt   one-cycle pulse for each cycle in which count_bin changed
//
// Handshake: there is no valid/ready interface; each button path produces a
// single-cycle registered request (req) that the counter consumes in the
// very next cycle with no back-pressure.

// Per-button path: synchroniser, debouncer, press detect and auto-repeat.
//   clk, rst  as above
//   raw       raw asynchronous button level
//   req       registered one-cycle step request
module updown_gray_btn #(
  parameter int DELAY       = 4,
  parameter int REPEAT      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic req
);

  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   level;
  logic                   armed;
  logic [CW-1:0]          db_cnt;
  logic [CW-1:0]          low_cnt;
  logic                   s;
  logic                   vld;
  logic                   differ;
  logic                   accept;
  logic                   rise;
  logic                   fire;

  assign s      = sync_q[SYNC_STAGES-1];
  // vld marks that the synchroniser holds a real sample, not reset fill.
  assign vld    = vld_q[SYNC_STAGES-1];
  assign differ = s ^ level;
  assign accept = differ && (db_cnt == CW'(DELAY - 1));
  assign rise   = accept && !level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      vld_q   <= '0;
      level   <= 1'b0;
      armed   <= 1'b0;
      db_cnt  <= '0;
      low_cnt <= '0;
      req     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};

      if (!differ) begin
        db_cnt <= '0;
      end else if (accept) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      // A button held through reset must be seen released (DELAY real low
      // samples while the accepted level is low) before presses count.
      if (vld && !s && !level) begin
        if (low_cnt == CW'(DELAY - 1)) armed <= 1'b1;
        else                           low_cnt <= low_cnt + 1'b1;
      end else begin
        low_cnt <= '0;
      end

      req <= armed & (rise | fire);
    end
  end

  if (REPEAT > 0) begin : g_rep
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    logic [RW-1:0] rep_cnt;

    // Counts cycles since acceptance (or since the last repeat) while held.
    always_ff @(posedge clk) begin
      if (rst) begin
        rep_cnt <= '0;
      end else if (!level || rep_cnt == RW'(REPEAT - 1)) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end

    assign fire = level && (rep_cnt == RW'(REPEAT - 1));
  end else begin : g_norep
    assign fire = 1'b0;
  end

endmodule

module updown_gray_counter_system #(
  parameter int N           = 4,
  parameter int DELAY       = 4,
  parameter int REPEAT      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_dn,
  input  logic         mode_gray,
  input  logic         wrap_en,
  output logic [N-1:0] leds,
  output logic [N-1:0] count_bin,
  output logic         step_evt
);

  localparam logic [N-1:0] MAX = '1;

  logic up_req;
  logic dn_req;

  updown_gray_btn #(
    .DELAY       (DELAY),
    .REPEAT      (REPEAT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_up (
    .clk (clk),
    .rst (rst),
    .raw (btn_up),
    .req (up_req)
  );

  updown_gray_btn #(
    .DELAY       (DELAY),
    .REPEAT      (REPEAT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_dn (
    .clk (clk),
    .rst (rst),
    .raw (btn_dn),
    .req (dn_req)
  );

  // Simultaneous requests cancel; step_evt only when the value really moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_bin <= '0;
      step_evt  <= 1'b0;
    end else begin
      step_evt <= 1'b0;
      if (up_req && !dn_req) begin
        if (count_bin != MAX) begin
          count_bin <= count_bin + 1'b1;
          step_evt  <= 1'b1;
        end else if (wrap_en) begin
          count_bin <= '0;
          step_evt  <= 1'b1;
        end
      end else if (dn_req && !up_req) begin
        if (count_bin != '0) begin
          count_bin <= count_bin - 1'b1;
          step_evt  <= 1'b1;
        end else if (wrap_en) begin
          count_bin <= MAX;
          step_evt  <= 1'b1;
        end
      end
    end
  end

  assign leds = mode_gray ? (count_bin ^ (count_bin >> 1)) : count_bin;

endmodule

// File: tb/tb_updown_gray_counter_system.sv
module tb_updown_gray_counter_system;

  localparam int N    = 4;
  localparam int DLY  = 4;
  localparam int S    = 2;
  localparam int REP1 = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_up;
  logic         btn_dn;
  logic         mode_gray;
  logic         wrap_en;
  logic [N-1:0] leds0, count0, leds1, count1;
  logic         step0, step1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int steps0 = 0, steps1 = 0;
  int chg0_q[$];
  int chg1_q[$];
  logic [31:0] exp_q[$];
  logic [N-1:0] prev0 = '0, prev1 = '0;

  // reference model state, index [dut][button] (button 0 = up, 1 = down)
  int m_sync[2][2][S];
  int m_level[2][2], m_run[2][2], m_held[2][2], m_lowrun[2][2];
  int m_armed[2][2], m_req[2][2];
  int m_count[2], m_step[2];
  int m_since;

  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  updown_gray_counter_system #(.N(N), .DELAY(DLY), .REPEAT(0), .SYNC_STAGES(S)) d0 (
    .clk (clk), .rst (rst), .btn_up (btn_up), .btn_dn (btn_dn),
    .mode_gray (mode_gray), .wrap_en (wrap_en),
    .leds (leds0), .count_bin (count0), .step_evt (step0)
  );

  updown_gray_counter_system #(.N(N), .DELAY(DLY), .REPEAT(REP1), .SYNC_STAGES(S)) d1 (
    .clk (clk), .rst (rst), .btn_up (btn_up), .btn_dn (btn_dn),
    .mode_gray (mode_gray), .wrap_en (wrap_en),
    .leds (leds1), .count_bin (count1), .step_evt (step1)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one clock edge, from the rules: a level is accepted
  // after DELAY consecutive disagreeing samples, presses step once plus one
  // per REPEAT cycles held, the counter wraps or clamps arithmetically.
  function automatic void model_edge(input logic r, input logic u, input logic dn, input logic w);
    int new_req[2][2];
    if (r) begin
      for (int d = 0; d < 2; d++) begin
        for (int b = 0; b < 2; b++) begin
          for (int k = 0; k < S; k++) m_sync[d][b][k] = 0;
          m_level[d][b] = 0; m_run[d][b] = 0; m_held[d][b] = 0;
          m_lowrun[d][b] = 0; m_armed[d][b] = 0; m_req[d][b] = 0;
        end
        m_count[d] = 0;
        m_step[d] = 0;
      end
      m_since = 0;
      return;
    end
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 2; b++) begin
        int raw, s, old_level, rose, fire, rep;
        raw = (b == 0) ? int'(u) : int'(dn);
        s = m_sync[d][b][S-1];
        old_level = m_level[d][b];
        rose = 0;
        fire = 0;
        rep = (d == 0) ? 0 : REP1;
        if (s != old_level) m_run[d][b]++;
        else m_run[d][b] = 0;
        if (m_run[d][b] == DLY) begin
          m_level[d][b] = s;
          m_run[d][b] = 0;
          rose = (s == 1) ? 1 : 0;
        end
        if (old_level == 1) begin
          m_held[d][b]++;
          if (rep > 0 && (m_held[d][b] % rep) == 0) fire = 1;
        end else begin
          m_held[d][b] = 0;
        end
        new_req[d][b] = (m_armed[d][b] != 0 && (rose != 0 || fire != 0)) ? 1 : 0;
        if (m_since >= S && s == 0 && old_level == 0) m_lowrun[d][b]++;
        else m_lowrun[d][b] = 0;
        if (m_lowrun[d][b] >= DLY) m_armed[d][b] = 1;
        for (int k = S - 1; k > 0; k--) m_sync[d][b][k] = m_sync[d][b][k-1];
        m_sync[d][b][0] = raw;
      end
    end
    for (int d = 0; d < 2; d++) begin
      int nxt;
      nxt = m_count[d];
      if (m_req[d][0] != 0 && m_req[d][1] == 0) nxt = m_count[d] + 1;
      else if (m_req[d][1] != 0 && m_req[d][0] == 0) nxt = m_count[d] - 1;
      if (nxt > (1 << N) - 1) nxt = w ? 0 : (1 << N) - 1;
      if (nxt < 0) nxt = w ? (1 << N) - 1 : 0;
      m_step[d] = (nxt != m_count[d]) ? 1 : 0;
      m_count[d] = nxt;
      m_req[d] = new_req[d];
    end
    m_since++;
  endfunction

  function automatic logic [N-1:0] exp_leds(input int c, input logic g);
    logic [N-1:0] v;
    v = N'(c);
    return g ? (v ^ (v >> 1)) : v;
  endfunction

  // one clock: model the edge, then sample outputs 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_edge(rst, btn_up, btn_dn, wrap_en);
    cyc++;
    #1;
    chk("count0", 32'(count0), 32'(m_count[0]));
    chk("step0",  32'(step0),  32'(m_step[0]));
    chk("leds0",  32'(leds0),  32'(exp_leds(m_count[0], mode_gray)));
    chk("count1", 32'(count1), 32'(m_count[1]));
    chk("step1",  32'(step1),  32'(m_step[1]));
    chk("leds1",  32'(leds1),  32'(exp_leds(m_count[1], mode_gray)));
    if (count0 !== prev0) chg0_q.push_back(cyc);
    if (count1 !== prev1) chg1_q.push_back(cyc);
    prev0 = count0;
    prev1 = count1;
    if (step0 === 1'b1) steps0++;
    if (step1 === 1'b1) steps1++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // driver tasks
  task automatic press(input logic u, input logic dn, input int hi, input int lo);
    btn_up = u;
    btn_dn = dn;
    ticks(hi);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    ticks(lo);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(20);
  endtask

  initial begin
    int t0, acc;
    rst = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    mode_gray = 1'b1;
    wrap_en = 1'b1;
    ticks(2);
    rst = 1'b0;

    // reset state, both display modes
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_step",  32'(step0),  32'd0);
    chk("rst_leds_gray", 32'(leds0), 32'd0);
    mode_gray = 1'b0;
    #1;
    chk("rst_leds_bin", 32'(leds0), 32'd0);
    mode_gray = 1'b1;
    ticks(20);

    // bounce rejection
    steps0 = 0;
    chg0_q.delete();
    btn_up = 1'b1; ticks(2);
    btn_up = 1'b0; ticks(1);
    btn_up = 1'b1; ticks(3);
    btn_up = 1'b0; ticks(1);
    btn_up = 1'b1;
    t0 = cyc + 1;
    ticks(10);
    btn_up = 1'b0;
    ticks(15);
    chk("bounce_count", 32'(count0), 32'd1);
    chk("bounce_steps", 32'(steps0), 32'd1);
    chk("bounce_nchg",  32'(chg0_q.size()), 32'd1);
    if (chg0_q.size() > 0) chk("bounce_latency", 32'(chg0_q[0]), 32'(t0 + S + DLY));

    // full Gray walk with wrap
    do_reset();
    steps0 = 0;
    for (int i = 1; i <= 16; i++) begin
      press(1'b1, 1'b0, 6, 8);
      chk("walk_leds",  32'(leds0),  32'(gray_tab[i % 16]));
      chk("walk_count", 32'(count0), 32'(i % 16));
    end
    chk("walk_steps", 32'(steps0), 32'd16);

    // saturation
    wrap_en = 1'b0;
    steps0 = 0;
    press(1'b0, 1'b1, 6, 8);
    chk("sat_low_count", 32'(count0), 32'd0);
    chk("sat_low_steps", 32'(steps0), 32'd0);
    for (int i = 0; i < 20; i++) press(1'b1, 1'b0, 6, 8);
    chk("sat_high_count", 32'(count0), 32'd15);
    chk("sat_high_steps", 32'(steps0), 32'd15);

    // simultaneous presses cancel; mode switch is immediate
    wrap_en = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 6, 8);
    steps0 = 0;
    press(1'b1, 1'b1, 6, 8);
    chk("both_count", 32'(count0), 32'd5);
    chk("both_steps", 32'(steps0), 32'd0);
    chk("mode_gray_leds", 32'(leds0), 32'h7);
    mode_gray = 1'b0;
    #1;
    chk("mode_bin_leds",  32'(leds0),  32'h5);
    chk("mode_bin_count", 32'(count0), 32'd5);
    mode_gray = 1'b1;

    // auto-repeat on the REPEAT=8 instance
    do_reset();
    chg1_q.delete();
    steps1 = 0;
    btn_up = 1'b1;
    t0 = cyc + 1;
    acc = t0 + S + DLY - 1;
    ticks(36);
    btn_up = 1'b0;
    ticks(30);
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(acc + 1 + k * REP1));
    chk("rep_count", 32'(count1), 32'd5);
    chk("rep_steps", 32'(steps1), 32'd5);
    chk("rep_nchg",  32'(chg1_q.size()), 32'd5);
    while (exp_q.size() > 0 && chg1_q.size() > 0) begin
      chk("rep_time", 32'(chg1_q.pop_front()), exp_q.pop_front());
    end
    exp_q.delete();
    chk("rep_norep_count", 32'(count0), 32'd1);

    // reset while held: no step until released and pressed again
    do_reset();
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 6, 8);
    chk("hold_pre_count", 32'(count0), 32'd9);
    btn_up = 1'b1;
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hold_rst_count", 32'(count0), 32'd0);
    chk("hold_rst_leds",  32'(leds0),  32'd0);
    chk("hold_rst_step",  32'(step0),  32'd0);
    steps0 = 0;
    ticks(30);
    chk("hold_held_count", 32'(count0), 32'd0);
    chk("hold_held_steps", 32'(steps0), 32'd0);
    btn_up = 1'b0;
    ticks(12);
    press(1'b1, 1'b0, 6, 8);
    chk("hold_repress_count", 32'(count0), 32'd1);

    // randomized phase, checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      btn_up    = 1'($urandom_range(0, 1));
      btn_dn    = 1'($urandom_range(0, 1));
      wrap_en   = 1'($urandom_range(0, 1));
      mode_gray = 1'($urandom_range(0, 1));
      ticks($urandom_range(1, 14));
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    ticks(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
